// File: rtl/spi_reg_ctrl.sv
// SPI-to-register-file bridge: decodes command/data frames from an SPI slave
// and shares a 16x16 register file with a local request/ack port.
module spi_reg_ctrl #(
    parameter logic [7:0] SIG = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ss,
    input  logic        spi_done,
    input  logic [15:0] spi_rx_data,
    output logic [15:0] spi_tx_data,
    output logic        spi_tx_en,
    input  logic        loc_req,
    input  logic        loc_we,
    input  logic [3:0]  loc_addr,
    input  logic [15:0] loc_wdata,
    output logic [15:0] loc_rdata,
    output logic        loc_ack,
    output logic        wr_pulse,
    output logic [3:0]  wr_addr,
    input  logic        err_clr,
    output logic        err_abort
);

    localparam logic [1:0] ST_CMD     = 2'd0;
    localparam logic [1:0] ST_WR_DATA = 2'd1;
    localparam logic [1:0] ST_RD_DATA = 2'd2;

    logic [1:0]  state;
    logic        done_prev;
    logic [3:0]  addr;
    logic [3:0]  next_addr;
    logic        burst;
    logic [15:0] tx_q;
    logic [15:0] regs [16];

    logic        frame_end;
    logic        frame_valid;
    logic        frame_abort;
    logic        spi_wr;
    logic        loc_go;
    logic        unused_cmd_bits;

    assign frame_end   = spi_done & ~done_prev;
    assign frame_valid = frame_end & ~ss;
    assign frame_abort = frame_end & ss;
    assign next_addr   = addr + 4'd1;

    assign spi_wr = (state == ST_WR_DATA) && frame_valid;
    // A pending ack blocks reissue so the requester has one cycle to drop loc_req.
    assign loc_go = loc_req && !loc_ack && !spi_wr;

    assign spi_tx_en   = (state != ST_WR_DATA);
    assign spi_tx_data = (state == ST_CMD) ? {SIG, 7'b0, err_abort} : tx_q;

    assign unused_cmd_bits = ^spi_rx_data[13:4];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_CMD;
            done_prev <= 1'b0;
            addr      <= 4'h0;
            burst     <= 1'b0;
            tx_q      <= 16'h0000;
            err_abort <= 1'b0;
        end else begin
            done_prev <= spi_done;

            if (frame_abort) begin
                err_abort <= 1'b1;
            end else if (err_clr) begin
                err_abort <= 1'b0;
            end

            case (state)
                ST_CMD: begin
                    if (frame_valid) begin
                        addr  <= spi_rx_data[3:0];
                        burst <= spi_rx_data[14];
                        if (spi_rx_data[15]) begin
                            state <= ST_WR_DATA;
                        end else begin
                            state <= ST_RD_DATA;
                            tx_q  <= regs[spi_rx_data[3:0]];
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (frame_valid) begin
                        if (burst) begin
                            addr <= next_addr;
                        end else begin
                            state <= ST_CMD;
                        end
                    end else if (ss) begin
                        state <= ST_CMD;
                    end
                end
                ST_RD_DATA: begin
                    // The word received during a read data frame is discarded.
                    if (frame_valid) begin
                        if (burst) begin
                            addr <= next_addr;
                            tx_q <= regs[next_addr];
                        end else begin
                            state <= ST_CMD;
                        end
                    end else if (ss) begin
                        state <= ST_CMD;
                    end
                end
                default: begin
                    state <= ST_CMD;
                end
            endcase
        end
    end

    // Register file and local port; an SPI write always takes the cycle first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) begin
                regs[i] <= 16'h0000;
            end
            wr_pulse  <= 1'b0;
            wr_addr   <= 4'h0;
            loc_ack   <= 1'b0;
            loc_rdata <= 16'h0000;
        end else begin
            wr_pulse <= 1'b0;
            loc_ack  <= loc_go;
            if (spi_wr) begin
                regs[addr] <= spi_rx_data;
                wr_pulse   <= 1'b1;
                wr_addr    <= addr;
            end else if (loc_go) begin
                if (loc_we) begin
                    regs[loc_addr] <= loc_wdata;
                    wr_pulse       <= 1'b1;
                    wr_addr        <= loc_addr;
                end else begin
                    loc_rdata <= regs[loc_addr];
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Randomized bench for spi_reg_ctrl with a transaction-level register model
// and a scoreboard of expected register-write notices.
module tb_spi_reg_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ss = 1'b1;
    logic        spi_done = 1'b0;
    logic [15:0] spi_rx_data = 16'h0000;
    logic [15:0] spi_tx_data;
    logic        spi_tx_en;
    logic        loc_req = 1'b0;
    logic        loc_we = 1'b0;
    logic [3:0]  loc_addr = 4'h0;
    logic [15:0] loc_wdata = 16'h0000;
    logic [15:0] loc_rdata;
    logic        loc_ack;
    logic        wr_pulse;
    logic [3:0]  wr_addr;
    logic        err_clr = 1'b0;
    logic        err_abort;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] model_regs [16];
    logic        model_err;
    int          exp_wr [$];
    int          got_wr [$];

    spi_reg_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .ss          (ss),
        .spi_done    (spi_done),
        .spi_rx_data (spi_rx_data),
        .spi_tx_data (spi_tx_data),
        .spi_tx_en   (spi_tx_en),
        .loc_req     (loc_req),
        .loc_we      (loc_we),
        .loc_addr    (loc_addr),
        .loc_wdata   (loc_wdata),
        .loc_rdata   (loc_rdata),
        .loc_ack     (loc_ack),
        .wr_pulse    (wr_pulse),
        .wr_addr     (wr_addr),
        .err_clr     (err_clr),
        .err_abort   (err_abort)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset && wr_pulse) got_wr.push_back(int'(wr_addr));
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0h required %0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [15:0] status_word(input logic e);
        return {8'hA5, 7'b0, e};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) model_regs[i] = 16'h0000;
        model_err = 1'b0;
        exp_wr.delete();
        got_wr.delete();
    endtask

    // One SPI frame: done rises with ss at the given level, then the slave idles.
    task automatic applyStimulus(input logic [15:0] word, input logic ss_end, input logic clr);
        spi_rx_data = word;
        ss          = ss_end;
        spi_done    = 1'b1;
        err_clr     = clr;
        tick(1);
        spi_done = 1'b0;
        err_clr  = 1'b0;
        tick(3);
    endtask

    task automatic check_wr_log();
        tick(1);
        checkOutput("wr_count", 32'(got_wr.size()), 32'(exp_wr.size()));
        for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++)
            checkOutput("wr_addr_seq", 32'(got_wr[i]), 32'(exp_wr[i]));
        got_wr.delete();
        exp_wr.delete();
    endtask

    task automatic loc_access(input logic we, input logic [3:0] a, input logic [15:0] d,
                              output logic [15:0] rd);
        int waited;
        loc_req   = 1'b1;
        loc_we    = we;
        loc_addr  = a;
        loc_wdata = d;
        waited    = 0;
        do begin
            tick(1);
            waited++;
        end while (!loc_ack && waited < 10);
        checkOutput("loc_latency", 32'(waited), 32'd1);
        rd      = loc_rdata;
        loc_req = 1'b0;
        loc_we  = 1'b0;
        if (we) begin
            model_regs[a] = d;
            exp_wr.push_back(int'(a));
        end
        tick(1);
        checkOutput("loc_ack_pulse", 32'(loc_ack), 32'd0);
    endtask

    task automatic loc_read_check(input string tag, input logic [3:0] a);
        logic [15:0] rd;
        loc_access(1'b0, a, 16'h0000, rd);
        checkOutput(tag, 32'(rd), 32'(model_regs[a]));
    endtask

    task automatic spi_write_txn(input logic [3:0] a, input logic burst, input int n);
        logic [15:0] d;
        logic [3:0]  cur;
        cur = a;
        applyStimulus({1'b1, burst, 10'($urandom), a}, 1'b0, 1'b0);
        checkOutput("wr_cmd_tx_en", 32'(spi_tx_en), 32'd0);
        for (int k = 0; k < n; k++) begin
            d = 16'($urandom);
            applyStimulus(d, 1'b0, 1'b0);
            model_regs[cur] = d;
            exp_wr.push_back(int'(cur));
            cur = cur + 4'd1;
            if (burst) checkOutput("wr_burst_tx_en", 32'(spi_tx_en), 32'd0);
        end
        if (burst) begin
            ss = 1'b1;
            tick(2);
        end
        checkOutput("wr_end_tx_en", 32'(spi_tx_en), 32'd1);
        checkOutput("wr_end_status", 32'(spi_tx_data), 32'(status_word(model_err)));
        check_wr_log();
    endtask

    task automatic spi_read_txn(input logic [3:0] a, input logic burst, input int n);
        logic [3:0] cur;
        cur = a;
        applyStimulus({1'b0, burst, 10'($urandom), a}, 1'b0, 1'b0);
        checkOutput("rd_first_data", 32'(spi_tx_data), 32'(model_regs[a]));
        checkOutput("rd_tx_en", 32'(spi_tx_en), 32'd1);
        if (burst) begin
            for (int k = 1; k < n; k++) begin
                applyStimulus(16'($urandom), 1'b0, 1'b0);
                cur = cur + 4'd1;
                checkOutput("rd_burst_data", 32'(spi_tx_data), 32'(model_regs[cur]));
            end
            ss = 1'b1;
            tick(2);
        end else begin
            applyStimulus(16'($urandom), 1'b0, 1'b0);
        end
        checkOutput("rd_end_status", 32'(spi_tx_data), 32'(status_word(model_err)));
        check_wr_log();
    endtask

    initial begin
        logic [15:0] rd;
        logic [3:0]  a;
        logic [15:0] d;

        model_reset();
        tick(2);
        checkOutput("rst_tx_data", 32'(spi_tx_data), 32'hA500);
        checkOutput("rst_tx_en", 32'(spi_tx_en), 32'd1);
        checkOutput("rst_loc_ack", 32'(loc_ack), 32'd0);
        checkOutput("rst_loc_rdata", 32'(loc_rdata), 32'd0);
        checkOutput("rst_wr_pulse", 32'(wr_pulse), 32'd0);
        checkOutput("rst_wr_addr", 32'(wr_addr), 32'd0);
        checkOutput("rst_err_abort", 32'(err_abort), 32'd0);
        reset = 1'b1;
        tick(2);
        for (int i = 0; i < 16; i++) loc_read_check("rst_reg", 4'(i));

        // Single write then read-back over SPI.
        applyStimulus(16'h8003, 1'b0, 1'b0);
        applyStimulus(16'h1234, 1'b0, 1'b0);
        model_regs[3] = 16'h1234;
        exp_wr.push_back(3);
        checkOutput("w3_status", 32'(spi_tx_data), 32'hA500);
        check_wr_log();
        loc_read_check("w3_reg", 4'd3);
        spi_rx_data = 16'h0003;
        ss          = 1'b0;
        spi_done    = 1'b1;
        tick(2);
        spi_done = 1'b0;
        checkOutput("r3_within_2clk", 32'(spi_tx_data), 32'h1234);
        tick(2);
        applyStimulus(16'h0000, 1'b0, 1'b0);
        checkOutput("r3_back_to_cmd", 32'(spi_tx_data), 32'hA500);
        ss = 1'b1;
        tick(1);

        // Burst write wrapping from 15 to 0.
        applyStimulus(16'hC00F, 1'b0, 1'b0);
        applyStimulus(16'h0001, 1'b0, 1'b0);
        applyStimulus(16'h0002, 1'b0, 1'b0);
        ss = 1'b1;
        tick(2);
        model_regs[15] = 16'h0001;
        model_regs[0]  = 16'h0002;
        exp_wr.push_back(15);
        exp_wr.push_back(0);
        check_wr_log();
        loc_read_check("wrap_reg15", 4'd15);
        loc_read_check("wrap_reg0", 4'd0);

        // Aborted data frame, then clear.
        applyStimulus(16'h8002, 1'b0, 1'b0);
        applyStimulus(16'hBEEF, 1'b1, 1'b0);
        model_err = 1'b1;
        checkOutput("abort_status", 32'(spi_tx_data), 32'hA501);
        checkOutput("abort_tx_en", 32'(spi_tx_en), 32'd1);
        checkOutput("abort_flag", 32'(err_abort), 32'd1);
        check_wr_log();
        loc_read_check("abort_reg2", 4'd2);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        tick(1);
        model_err = 1'b0;
        checkOutput("clr_status", 32'(spi_tx_data), 32'hA500);

        // Abort coinciding with clear keeps the flag set.
        applyStimulus(16'h0004, 1'b0, 1'b0);
        applyStimulus(16'h5A5A, 1'b1, 1'b1);
        model_err = 1'b1;
        checkOutput("set_wins_flag", 32'(err_abort), 32'd1);
        checkOutput("set_wins_status", 32'(spi_tx_data), 32'hA501);

        // Local write colliding with an SPI write to the same address.
        applyStimulus(16'h8005, 1'b0, 1'b0);
        spi_rx_data = 16'hAAAA;
        spi_done    = 1'b1;
        loc_req     = 1'b1;
        loc_we      = 1'b1;
        loc_addr    = 4'd5;
        loc_wdata   = 16'h5555;
        tick(1);
        spi_done = 1'b0;
        checkOutput("col_spi_pulse", 32'(wr_pulse), 32'd1);
        checkOutput("col_spi_addr", 32'(wr_addr), 32'd5);
        checkOutput("col_ack_deferred", 32'(loc_ack), 32'd0);
        tick(1);
        checkOutput("col_loc_ack", 32'(loc_ack), 32'd1);
        checkOutput("col_loc_pulse", 32'(wr_pulse), 32'd1);
        checkOutput("col_loc_addr", 32'(wr_addr), 32'd5);
        loc_req = 1'b0;
        loc_we  = 1'b0;
        tick(3);
        model_regs[5] = 16'h5555;
        exp_wr.push_back(5);
        exp_wr.push_back(5);
        check_wr_log();
        loc_read_check("col_reg5", 4'd5);
        ss = 1'b1;
        tick(1);

        // Randomized mix of SPI and local transactions.
        for (int it = 0; it < 60; it++) begin
            a = 4'($urandom);
            d = 16'($urandom);
            case ($urandom_range(0, 6))
                0: spi_write_txn(a, 1'b0, 1);
                1: spi_write_txn(a, 1'b1, $urandom_range(1, 5));
                2: spi_read_txn(a, 1'b0, 1);
                3: spi_read_txn(a, 1'b1, $urandom_range(2, 5));
                4: begin
                    loc_access(1'b1, a, d, rd);
                    check_wr_log();
                end
                5: loc_read_check("rand_loc_read", a);
                default: begin
                    err_clr = 1'b1;
                    tick(1);
                    err_clr = 1'b0;
                    tick(1);
                    model_err = 1'b0;
                    checkOutput("rand_clr_status", 32'(spi_tx_data), 32'(status_word(model_err)));
                end
            endcase
        end
        for (int i = 0; i < 16; i++) loc_read_check("final_scan", 4'(i));

        // Reset in the middle of a write transaction.
        applyStimulus(16'h8007, 1'b0, 1'b0);
        reset = 1'b0;
        tick(1);
        model_reset();
        reset = 1'b1;
        tick(1);
        checkOutput("midrst_status", 32'(spi_tx_data), 32'hA500);
        applyStimulus(16'h1234, 1'b0, 1'b0);
        checkOutput("midrst_is_cmd", 32'(spi_tx_en), 32'd1);
        checkOutput("midrst_rd_data", 32'(spi_tx_data), 32'(model_regs[4]));
        applyStimulus(16'h0000, 1'b0, 1'b0);
        ss = 1'b1;
        check_wr_log();
        loc_read_check("midrst_reg7", 4'd7);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
